fwrisc_sram_target: RTL
=======================

FWRISC_SRAM_TARGET -- requirements
Module: fwrisc_sram_target

Interface
REQ-001 Parameter DAT_WIDTH, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADR_WIDTH, default 22, word-address width; depth = 2**ADR_WIDTH words.
REQ-003 Parameter I_WAIT, default 0, maximum instruction-port wait states.
REQ-004 Parameter D_WAIT, default 0, maximum data-port wait states.
REQ-005 Parameter RAND_WAIT, default 0; 0 = fixed wait of exactly I_WAIT/D_WAIT, 1 = pseudo-random wait in 0..I_WAIT/D_WAIT.
REQ-006 Parameter SEED, default 32'h1, non-zero LFSR seed.
REQ-007 clock  input  1  sole clock; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 iaddr  input  32  instruction byte address.
REQ-010 ivalid  input  1  instruction read request.
REQ-011 iready  output  1  one-cycle completion pulse; idata valid in the same cycle.
REQ-012 idata  output  DAT_WIDTH  instruction read data.
REQ-013 daddr  input  32  data byte address.
REQ-014 dwdata  input  DAT_WIDTH  write data.
REQ-015 dwstb  input  DAT_WIDTH/8  byte write strobes.
REQ-016 dwrite  input  1  1 = write, 0 = read.
REQ-017 dvalid  input  1  data request.
REQ-018 dready  output  1  one-cycle completion pulse; drdata valid in the same cycle.
REQ-019 drdata  output  DAT_WIDTH  data read data.

Function
REQ-020 Each port SHALL run an independent FSM: IDLE -> WAIT (request sampled) -> RESP (ready=1 for one cycle) -> IDLE.
REQ-021 IDLE->WAIT on valid=1; wait counter SHALL load the fixed value, or LFSR[..] mod (MAX+1) when RAND_WAIT=1.
REQ-022 WAIT SHALL decrement the counter each cycle and go to RESP the cycle after the counter reaches 0; latency valid->ready = wait+1 cycles.
REQ-023 Word index SHALL be addr[ADR_WIDTH+1:2]; addr bits [1:0] and above ADR_WIDTH+1 ignored (address wraps modulo depth).
REQ-024 Reads SHALL return the array word at RESP; writes SHALL update only strobed bytes, committed in the RESP cycle.
REQ-025 Master SHALL hold addr/data/strobe/write stable from valid until ready; target samples them in the RESP cycle.
REQ-026 If valid drops during WAIT, FSM SHALL return to IDLE without ready and without committing a write.
REQ-027 valid held high after RESP SHALL start a new request; the FSM passes through IDLE for one cycle (min 2-cycle repeat interval).
REQ-028 Same-cycle I read and D write to the same word: I port SHALL return pre-write data (read-before-write).
REQ-029 dwrite=1 with dwstb=0 SHALL complete with dready=1 and leave memory unchanged.
REQ-030 drdata SHALL hold the last read value on writes and between transactions; idata likewise.
REQ-031 One 32-bit Galois LFSR (taps 32,22,2,1) SHALL advance every cycle; I port uses bits [15:0], D port bits [31:16].

Reset
REQ-032 On reset: both FSMs IDLE, counters 0, iready=0, dready=0, idata=0, drdata=0, LFSR=SEED.
REQ-033 Reset mid-transaction SHALL abort it; a pending write SHALL NOT be committed.
REQ-034 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-035 FSM state enum and LFSR tap constant SHALL live in shared package fwrisc_sram_target_pkg.
REQ-036 Per-port handshake/wait logic SHALL be one sub-module fwrisc_sram_port_ctrl, instantiated twice.
REQ-037 Array SHALL be a single behavioural dual-port byte-enable memory inside fwrisc_sram_target.

Verification
REQ-038 I_WAIT=0: ivalid=1 at 0x100 holding 0xDEADBEEF -> iready=1 with idata=0xDEADBEEF exactly 1 cycle later.
REQ-039 D_WAIT=3: write 0x11223344 strobe 4'b0101 over 0xAABBCCDD at 0x200 -> dready at cycle 4; readback 0xAA22CC44.
REQ-040 Same cycle: D write 0x5 to 0x40, I read 0x40 (old 0x7), both wait 0 -> idata=0x7; next I read returns 0x5.
REQ-041 ADR_WIDTH=4: write 0x9 to byte address 0x40 -> read of 0x0 returns 0x9.
REQ-042 D_WAIT=5: reset asserted in 3rd WAIT cycle of write -> dready never pulses; location unchanged.
REQ-043 RAND_WAIT=1, D_WAIT=7: 1000 reads -> every latency in 1..8; all eight values observed.

Source files
------------

// File: rtl/fwrisc_sram_target_pkg.sv
// Shared types and constants for the SRAM target model.
// Holds the per-port handshake state encoding and the wait-state LFSR.
package fwrisc_sram_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } port_state_e;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/fwrisc_sram_port_ctrl.sv
// Per-port request handshake: counts wait states and pulses ready for one cycle.
// Latency valid->ready = wait+1 cycles; wait is fixed or drawn from rnd.
// No backpressure on the target side; dropping valid before ready abandons the request.
module fwrisc_sram_port_ctrl
    import fwrisc_sram_target_pkg::*;
#(
    parameter int MAX_WAIT  = 0,
    parameter int RAND_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [15:0] rnd,
    output logic        ready,
    output logic        fire
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    port_state_e    state;
    logic [CW-1:0]  count;
    logic [CW-1:0]  load_val;

    always_comb begin
        load_val = CW'(MAX_WAIT);
        if (RAND_WAIT != 0) begin
            load_val = CW'(rnd % 16'(MAX_WAIT + 1));
        end
    end

    // The cycle that moves the FSM into RESP is where the top samples the
    // request, so a zero-wait request skips WAIT to keep a one-cycle latency.
    always_comb begin
        fire = 1'b0;
        if (!reset && valid) begin
            if (state == ST_IDLE && load_val == '0) begin
                fire = 1'b1;
            end else if (state == ST_WAIT && count == '0) begin
                fire = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            ready <= 1'b0;
        end else begin
            ready <= fire;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        if (load_val == '0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            count <= load_val - CW'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!valid) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else if (count == '0) begin
                        state <= ST_RESP;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fwrisc_sram_target.sv
// Dual-port (instruction read / data read-write) SRAM target with configurable wait states.
// Latency valid->ready = wait+1 cycles per port; ports run independently.
// Master holds the request until the ready pulse; the target never stalls beyond the wait count.
module fwrisc_sram_target
    import fwrisc_sram_target_pkg::*;
#(
    parameter int          DAT_WIDTH = 32,
    parameter int          ADR_WIDTH = 22,
    parameter int          I_WAIT    = 0,
    parameter int          D_WAIT    = 0,
    parameter int          RAND_WAIT = 0,
    parameter logic [31:0] SEED      = 32'h1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            iaddr,
    input  logic                   ivalid,
    output logic                   iready,
    output logic [DAT_WIDTH-1:0]   idata,
    input  logic [31:0]            daddr,
    input  logic [DAT_WIDTH-1:0]   dwdata,
    input  logic [DAT_WIDTH/8-1:0] dwstb,
    input  logic                   dwrite,
    input  logic                   dvalid,
    output logic                   dready,
    output logic [DAT_WIDTH-1:0]   drdata
);

    localparam int NB    = DAT_WIDTH / 8;
    localparam int DEPTH = 2 ** ADR_WIDTH;

    logic [31:0]          lfsr;
    logic                 i_fire;
    logic                 d_fire;
    logic [ADR_WIDTH-1:0] iidx;
    logic [ADR_WIDTH-1:0] didx;
    logic                 unused_addr;

    logic [DAT_WIDTH-1:0] mem [DEPTH];

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign iidx        = iaddr[ADR_WIDTH+1:2];
    assign didx        = daddr[ADR_WIDTH+1:2];
    assign unused_addr = ^{iaddr, daddr};

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    fwrisc_sram_port_ctrl #(
        .MAX_WAIT  (I_WAIT),
        .RAND_WAIT (RAND_WAIT)
    ) u_iport (
        .clock (clock),
        .reset (reset),
        .valid (ivalid),
        .rnd   (lfsr[15:0]),
        .ready (iready),
        .fire  (i_fire)
    );

    fwrisc_sram_port_ctrl #(
        .MAX_WAIT  (D_WAIT),
        .RAND_WAIT (RAND_WAIT)
    ) u_dport (
        .clock (clock),
        .reset (reset),
        .valid (dvalid),
        .rnd   (lfsr[31:16]),
        .ready (dready),
        .fire  (d_fire)
    );

    // Array is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (d_fire && dwrite) begin
            for (int b = 0; b < NB; b++) begin
                if (dwstb[b]) begin
                    mem[didx][b*8 +: 8] <= dwdata[b*8 +: 8];
                end
            end
        end
    end

    // Reads sample the array on the same edge as a write commit, so a
    // colliding instruction fetch sees the pre-write word.
    always_ff @(posedge clock) begin
        if (reset) begin
            idata  <= '0;
            drdata <= '0;
        end else begin
            if (i_fire) begin
                idata <= mem[iidx];
            end
            if (d_fire && !dwrite) begin
                drdata <= mem[didx];
            end
        end
    end

endmodule
